// File: rtl/speed_tick_gen_if.sv
// Control and tick bundle for speed_tick_gen: per-channel enables, shared speed and restart in;
// per-channel tick pulses and divided clocks out.
interface speed_tick_gen_if #(
    parameter int unsigned CH      = 2,
    parameter int unsigned SCORE_W = 4
);
    logic [CH-1:0]      en;
    logic               restart;
    logic [SCORE_W-1:0] score;
    logic [CH-1:0]      tick;
    logic [CH-1:0]      div_clk;

    modport master (
        output en,
        output restart,
        output score,
        input  tick,
        input  div_clk
    );

    modport slave (
        input  en,
        input  restart,
        input  score,
        output tick,
        output div_clk
    );
endinterface

// File: rtl/speed_tick_gen.sv
// Multi-channel phase-accumulator tick generator. Each channel adds BASE_STEP + latched score per
// cycle and wraps at EXPIRE, keeping the remainder so the long-run tick rate has no drift.
module speed_tick_gen #(
    parameter int unsigned CH        = 2,
    parameter int unsigned SCORE_W   = 4,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned BASE_STEP = 25,
    parameter int unsigned EXPIRE    = 250000000
) (
    input  logic               clk,
    input  logic               rst_n,
    speed_tick_gen_if.slave    bus
);

    localparam logic [CNT_W-1:0] ExpireC = CNT_W'(EXPIRE);
    localparam logic [CNT_W-1:0] BaseC   = CNT_W'(BASE_STEP);

    // Channels start evenly spread over one period so their ticks do not coincide.
    function automatic logic [CNT_W-1:0] preload(input int unsigned k);
        return CNT_W'((64'(k) * 64'(EXPIRE)) / 64'(CH));
    endfunction

    logic [CNT_W-1:0]   acc_q [CH];
    logic [CNT_W-1:0]   acc_d [CH];
    logic [SCORE_W-1:0] lat_q [CH];
    logic [SCORE_W-1:0] lat_d [CH];
    logic [CNT_W-1:0]   sum   [CH];
    logic [CH-1:0]      tick_q, tick_d;
    logic [CH-1:0]      div_q, div_d;

    always_comb begin
        tick_d = '0;
        div_d  = div_q;
        for (int unsigned k = 0; k < CH; k++) begin
            acc_d[k] = acc_q[k];
            lat_d[k] = lat_q[k];
            sum[k]   = acc_q[k] + BaseC + CNT_W'(lat_q[k]);
            if (bus.restart) begin
                acc_d[k] = preload(k);
                div_d[k] = 1'b0;
                lat_d[k] = bus.score;
            end else if (bus.en[k]) begin
                if (sum[k] >= ExpireC) begin
                    // Remainder is carried so fractional periods accumulate correctly.
                    acc_d[k]  = sum[k] - ExpireC;
                    tick_d[k] = 1'b1;
                    div_d[k]  = ~div_q[k];
                    lat_d[k]  = bus.score;
                end else begin
                    acc_d[k] = sum[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
            div_q  <= '0;
            for (int unsigned k = 0; k < CH; k++) begin
                acc_q[k] <= preload(k);
                lat_q[k] <= '0;
            end
        end else begin
            tick_q <= tick_d;
            div_q  <= div_d;
            for (int unsigned k = 0; k < CH; k++) begin
                acc_q[k] <= acc_d[k];
                lat_q[k] <= lat_d[k];
            end
        end
    end

    assign bus.tick    = tick_q;
    assign bus.div_clk = div_q;

endmodule
